// File: rtl/replicate_pkg.sv
// Shared types, default configuration and helper functions for the replicate_stream block.
package replicate_pkg;

  localparam int unsigned DefW      = 8;
  localparam int unsigned DefLanes  = 4;
  localparam int unsigned DefMaxRep = 15;
  localparam int unsigned MaskW     = 32;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  // Low `count` bits set; callers truncate to their lane count (at most MaskW lanes).
  function automatic logic [MaskW-1:0] lane_mask(input int unsigned count);
    if (count >= MaskW) return '1;
    return (MaskW'(1) << count) - MaskW'(1);
  endfunction

  function automatic int unsigned min_rep(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/replicate_lanes.sv
// Combinational beat builder: copies one word into the lowest count_i lanes, zeroes the rest.
module replicate_lanes
  import replicate_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned Lanes = DefLanes,
  parameter int unsigned NW    = $clog2(Lanes + 1)
) (
  input  logic [W-1:0]       word_i,
  input  logic [NW-1:0]      count_i,
  output logic [Lanes*W-1:0] data_o,
  output logic [Lanes-1:0]   mask_o
);

  always_comb begin
    mask_o = Lanes'(lane_mask(32'(count_i)));
    data_o = '0;
    for (int i = 0; i < Lanes; i++) begin
      data_o[i*W +: W] = mask_o[i] ? word_i : '0;
    end
  end

endmodule

// File: rtl/replicate_stream.sv
// Streaming replicator: one word plus repeat count in, Lanes-wide masked beats out.
module replicate_stream
  import replicate_pkg::*;
#(
  parameter  int unsigned W      = DefW,
  parameter  int unsigned Lanes  = DefLanes,
  parameter  int unsigned MaxRep = DefMaxRep,
  localparam int unsigned CW     = $clog2(MaxRep + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [W-1:0]       in_data_i,
  input  logic [CW-1:0]      in_rep_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [Lanes*W-1:0] out_data_o,
  output logic [Lanes-1:0]   out_mask_o,
  output logic               out_last_o,
  output logic               zero_drop_o
);

  localparam int unsigned NW = $clog2(Lanes + 1);

  state_e             state_q, state_d;
  logic [W-1:0]       word_q, word_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [Lanes*W-1:0] out_data_q, out_data_d;
  logic [Lanes-1:0]   out_mask_q, out_mask_d;
  logic               out_last_q, out_last_d;
  logic               zero_drop_q, zero_drop_d;

  logic               accept, fire;
  logic [CW-1:0]      rep_clamped;
  logic [NW-1:0]      beat_n;
  logic [Lanes*W-1:0] beat_data;
  logic [Lanes-1:0]   beat_mask;

  always_comb begin
    rep_clamped = CW'(min_rep(32'(in_rep_i), MaxRep));
    accept      = (state_q == StIdle) && in_valid_i;
    fire        = (state_q == StEmit) && out_ready_i;
    state_d     = state_q;
    word_d      = word_q;
    rem_d       = rem_q;
    zero_drop_d = 1'b0;
    if (accept) begin
      word_d = in_data_i;
      rem_d  = rep_clamped;
      if (rep_clamped == '0) begin
        zero_drop_d = 1'b1;
      end else begin
        state_d = StEmit;
      end
    end else if (fire) begin
      if (out_last_q) begin
        state_d = StIdle;
        rem_d   = '0;
      end else begin
        // Not last implies rem_q > Lanes, so this cannot underflow.
        rem_d = CW'(32'(rem_q) - Lanes);
      end
    end
    beat_n = NW'(min_rep(32'(rem_d), Lanes));
  end

  replicate_lanes #(
    .W     (W),
    .Lanes (Lanes),
    .NW    (NW)
  ) u_lanes (
    .word_i  (word_d),
    .count_i (beat_n),
    .data_o  (beat_data),
    .mask_o  (beat_mask)
  );

  // Outputs are rebuilt every cycle from next state; a stall leaves inputs unchanged.
  always_comb begin
    out_data_d = '0;
    out_mask_d = '0;
    out_last_d = 1'b0;
    if (state_d == StEmit) begin
      out_data_d = beat_data;
      out_mask_d = beat_mask;
      out_last_d = (32'(rem_d) <= Lanes);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      word_q      <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StEmit);
  assign out_data_o  = out_data_q;
  assign out_mask_o  = out_mask_q;
  assign out_last_o  = out_last_q;
  assign zero_drop_o = zero_drop_q;

  logic [Lanes*W-1:0] mask_bits;
  always_comb begin
    mask_bits = '0;
    for (int i = 0; i < Lanes; i++) begin
      mask_bits[i*W +: W] = {W{out_mask_q[i]}};
    end
  end

  a_ready_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    in_ready_o == !out_valid_o);
  a_mask_data: assert property (@(posedge clk_i) disable iff (reset_i)
    out_data_q == ({Lanes{word_q}} & mask_bits));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (out_valid_o && !out_ready_i) |=>
      ($stable(out_data_q) && $stable(out_mask_q) && $stable(out_last_q)));

endmodule

// File: tb/tb_replicate_stream.sv
// Scoreboard bench: dut 0 uses defaults (MaxRep=15), dut 1 uses MaxRep=10 to exercise clamping.
module tb_replicate_stream;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  in_data  [2];
  logic [3:0]  in_rep   [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [31:0] out_data [2];
  logic [3:0]  out_mask [2];
  logic        out_last [2];
  logic        zero_drop[2];

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  replicate_stream u_dut0 (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(in_data[0]), .in_rep_i(in_rep[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(out_data[0]), .out_mask_o(out_mask[0]),
    .out_last_o(out_last[0]), .zero_drop_o(zero_drop[0])
  );

  replicate_stream #(.MaxRep(10)) u_dut1 (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(in_data[1]), .in_rep_i(in_rep[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(out_data[1]), .out_mask_o(out_mask[1]),
    .out_last_o(out_last[1]), .zero_drop_o(zero_drop[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted beat is checked against the head of the queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset && out_valid[k] && out_ready[k]) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected dut%0d: got data=%h mask=%h last=%b, none expected",
                   k, out_data[k], out_mask[k], out_last[k]);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (e.dut !== k || out_data[k] !== e.data || out_mask[k] !== e.mask ||
              out_last[k] !== e.last) begin
            fails++;
            $display("FAIL beat dut%0d: got data=%h mask=%h last=%b, want dut%0d data=%h mask=%h last=%b",
                     k, out_data[k], out_mask[k], out_last[k], e.dut, e.data, e.mask, e.last);
          end
        end
      end
    end
  end

  task automatic push_expected(input int k, input logic [7:0] word, input int rep);
    int max_rep;
    int rem;
    max_rep = (k == 0) ? 15 : 10;
    rem = (rep > max_rep) ? max_rep : rep;
    while (rem > 0) begin
      beat_t b;
      int n;
      n = (rem < 4) ? rem : 4;
      b.dut  = k;
      b.data = '0;
      b.mask = '0;
      for (int i = 0; i < n; i++) begin
        b.data[i*8 +: 8] = word;
        b.mask[i] = 1'b1;
      end
      b.last = (rem <= 4);
      exp_q.push_back(b);
      rem = (rem > 4) ? rem - 4 : 0;
    end
  endtask

  task automatic send(input int k, input logic [7:0] word, input int rep);
    int waited = 0;
    while (!in_ready[k] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready[k]) begin
      tests++;
      fails++;
      $display("FAIL send_timeout dut%0d: in_ready=%b, want 1", k, in_ready[k]);
    end
    push_expected(k, word, rep);
    in_valid[k] = 1'b1;
    in_data[k]  = word;
    in_rep[k]   = 4'(rep);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (!(exp_q.size() == 0 && in_ready[0] && in_ready[1]) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    tests++;
    if (exp_q.size() != 0 || !in_ready[0] || !in_ready[1]) begin
      fails++;
      $display("FAIL drain_timeout: pending=%0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 32'h0 || out_mask[0] !== 4'h0 ||
        out_last[0] !== 1'b0 || zero_drop[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        in_ready[1] !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h mask=%h last=%b zd=%b rdy=%b/%b, want 0 0 0 0 0 1/1",
               out_valid[0], out_data[0], out_mask[0], out_last[0], zero_drop[0],
               in_ready[0], in_ready[1]);
    end
  endtask

  task automatic test_single_beat();
    send(0, 8'hA5, 4);
    @(negedge clk);
    tests++;
    if (out_valid[0] !== 1'b1) begin
      fails++;
      $display("FAIL latency_one: out_valid=%b, want 1", out_valid[0]);
    end
    drain();
  endtask

  task automatic test_two_beats();
    send(0, 8'hA5, 6);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_last: in_ready=%b out_valid=%b, want 1 0",
               in_ready[0], out_valid[0]);
    end
    drain();
  endtask

  task automatic test_zero_rep();
    send(0, 8'hA5, 0);
    @(negedge clk);
    tests++;
    if (zero_drop[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL zero_pulse: zero_drop=%b out_valid=%b, want 1 0", zero_drop[0], out_valid[0]);
    end
    @(negedge clk);
    tests++;
    if (zero_drop[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL zero_end: zero_drop=%b in_ready=%b out_valid=%b, want 0 1 0",
               zero_drop[0], in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_rep_one();
    send(0, 8'hA5, 1);
    drain();
  endtask

  task automatic test_stall();
    send(0, 8'hA5, 9);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hA5A5A5A5 || out_mask[0] !== 4'hF ||
          out_last[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold c%0d: valid=%b data=%h mask=%h last=%b rdy=%b, want 1 a5a5a5a5 f 0 0",
                 c, out_valid[0], out_data[0], out_mask[0], out_last[0], in_ready[0]);
      end
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    drain();
  endtask

  task automatic test_clamp();
    send(0, 8'h3C, 15);
    drain();
    send(1, 8'h5A, 14);
    drain();
  endtask

  task automatic test_reset_mid();
    send(0, 8'hA5, 9);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_data[0] !== 32'h0 ||
        out_mask[0] !== 4'h0 || out_last[0] !== 1'b0 || zero_drop[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b rdy=%b data=%h mask=%h last=%b zd=%b, want 0 1 0 0 0 0",
               out_valid[0], in_ready[0], out_data[0], out_mask[0], out_last[0], zero_drop[0]);
    end
    send(0, 8'hA5, 2);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 5; r++) begin
      send(0, 8'($urandom), int'($urandom_range(1, 15)));
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      in_rep[k]    = '0;
      out_ready[k] = 1'b1;
    end
    test_reset();
    test_single_beat();
    test_two_beats();
    test_zero_rep();
    test_rep_one();
    test_stall();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
